// File: rtl/router_dest_reader.sv
// router_dest_reader
//   Destination-side drain for one router output FIFO. After the FIFO reports
//   data and an optional start delay elapses, pops one packet
//   (header, len payload bytes, parity), streams the payload, checks parity
//   and keeps saturating good/bad packet counters.
// Ports
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   valid_out, data_out FIFO not-empty flag and read data (valid the cycle after a pop)
//   soft_reset          FIFO flush; aborts the current packet
//   start_dly           cycles to wait before the first pop (0 = none)
//   read_enb            FIFO pop request (high in HDR and BODY)
//   busy                high whenever not IDLE
//   pyld_data/valid     payload byte and its one-cycle strobe
//   pkt_addr/pkt_len    fields of the last captured header
//   pkt_done/pkt_err    one-cycle parity good/bad pulse
//   pkt_count/err_count saturating good/bad packet counters
module router_dest_reader #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              valid_out,
    input  logic [DATA_W-1:0] data_out,
    input  logic              soft_reset,
    input  logic [4:0]        start_dly,
    output logic              read_enb,
    output logic              busy,
    output logic [DATA_W-1:0] pyld_data,
    output logic              pyld_valid,
    output logic [1:0]        pkt_addr,
    output logic [5:0]        pkt_len,
    output logic              pkt_done,
    output logic              pkt_err,
    output logic [CNT_W-1:0]  pkt_count,
    output logic [CNT_W-1:0]  err_count
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] DLY   = 3'd1;
    localparam logic [2:0] HDR   = 3'd2;
    localparam logic [2:0] HWAIT = 3'd3;
    localparam logic [2:0] BODY  = 3'd4;
    localparam logic [2:0] DRAIN = 3'd5;
    localparam logic [2:0] CHECK = 3'd6;

    logic [2:0]        state_q, state_d;
    logic [4:0]        dly_q, dly_d;
    logic              fire_q, fire_d;
    logic [6:0]        issue_rem_q, issue_rem_d;
    logic [5:0]        pyld_rem_q, pyld_rem_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [1:0]        pkt_addr_q, pkt_addr_d;
    logic [5:0]        pkt_len_q, pkt_len_d;
    logic [DATA_W-1:0] pyld_data_q, pyld_data_d;
    logic              pyld_valid_q, pyld_valid_d;
    logic [CNT_W-1:0]  pkt_count_q, pkt_count_d;
    logic [CNT_W-1:0]  err_count_q, err_count_d;
    logic              fire;
    logic              parity_ok;

    assign read_enb   = (state_q == HDR) || (state_q == BODY);
    assign fire       = read_enb && valid_out;
    assign busy       = (state_q != IDLE);
    assign parity_ok  = (acc_q == '0);
    // Pulses are suppressed when a flush coincides with CHECK, matching the
    // counters which do not move in that case.
    assign pkt_done   = (state_q == CHECK) && parity_ok && !soft_reset;
    assign pkt_err    = (state_q == CHECK) && !parity_ok && !soft_reset;
    assign pyld_data  = pyld_data_q;
    assign pyld_valid = pyld_valid_q;
    assign pkt_addr   = pkt_addr_q;
    assign pkt_len    = pkt_len_q;
    assign pkt_count  = pkt_count_q;
    assign err_count  = err_count_q;

    always_comb begin
        state_d      = state_q;
        dly_d        = dly_q;
        fire_d       = fire;
        issue_rem_d  = issue_rem_q;
        pyld_rem_d   = pyld_rem_q;
        acc_d        = acc_q;
        pkt_addr_d   = pkt_addr_q;
        pkt_len_d    = pkt_len_q;
        pyld_data_d  = pyld_data_q;
        pyld_valid_d = 1'b0;
        pkt_count_d  = pkt_count_q;
        err_count_d  = err_count_q;

        if (soft_reset) begin
            state_d = IDLE;
            fire_d  = 1'b0;
        end else begin
            // Bytes captured after the header: the first pyld_rem are payload,
            // the remaining one is parity. All of them fold into the accumulator.
            if (fire_q && (state_q == BODY || state_q == DRAIN)) begin
                acc_d = acc_q ^ data_out;
                if (pyld_rem_q != '0) begin
                    pyld_data_d  = data_out;
                    pyld_valid_d = 1'b1;
                    pyld_rem_d   = pyld_rem_q - 6'd1;
                end
            end

            case (state_q)
                IDLE: begin
                    if (valid_out) begin
                        if (start_dly != '0) begin
                            dly_d   = start_dly;
                            state_d = DLY;
                        end else begin
                            state_d = HDR;
                        end
                    end
                end
                DLY: begin
                    if (dly_q <= 5'd1) state_d = HDR;
                    else               dly_d   = dly_q - 5'd1;
                end
                HDR: begin
                    if (fire) state_d = HWAIT;
                end
                HWAIT: begin
                    if (fire_q) begin
                        pkt_addr_d  = data_out[1:0];
                        pkt_len_d   = data_out[7:2];
                        acc_d       = data_out;
                        pyld_rem_d  = data_out[7:2];
                        issue_rem_d = {1'b0, data_out[7:2]} + 7'd1;
                        state_d     = BODY;
                    end
                end
                BODY: begin
                    if (fire) begin
                        issue_rem_d = issue_rem_q - 7'd1;
                        if (issue_rem_q == 7'd1) state_d = DRAIN;
                    end
                end
                DRAIN: begin
                    if (fire_q) state_d = CHECK;
                end
                CHECK: begin
                    if (parity_ok) begin
                        if (pkt_count_q != '1) pkt_count_d = pkt_count_q + CNT_W'(1);
                    end else begin
                        if (err_count_q != '1) err_count_d = err_count_q + CNT_W'(1);
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            dly_q        <= '0;
            fire_q       <= 1'b0;
            issue_rem_q  <= '0;
            pyld_rem_q   <= '0;
            acc_q        <= '0;
            pkt_addr_q   <= '0;
            pkt_len_q    <= '0;
            pyld_data_q  <= '0;
            pyld_valid_q <= 1'b0;
            pkt_count_q  <= '0;
            err_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            dly_q        <= dly_d;
            fire_q       <= fire_d;
            issue_rem_q  <= issue_rem_d;
            pyld_rem_q   <= pyld_rem_d;
            acc_q        <= acc_d;
            pkt_addr_q   <= pkt_addr_d;
            pkt_len_q    <= pkt_len_d;
            pyld_data_q  <= pyld_data_d;
            pyld_valid_q <= pyld_valid_d;
            pkt_count_q  <= pkt_count_d;
            err_count_q  <= err_count_d;
        end
    end

endmodule
